// File: rtl/cdc_req_sender.sv
// Source-side 4-phase req/ack sender for an enable/data synchronizer; CDC_REQ_SENDER_TIMEOUT_EN adds a per-phase abort (err).
// Latency: data and enable launch on the accept edge; in_ready held low from accept until ack_sync is seen low again.
module cdc_req_sender #(
    parameter int DATA_W      = 1,
    parameter int MIN_HOLD    = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] sync_data,
    output logic              sync_enable,
    input  logic              ack_sync,
    output logic              busy,
    output logic [15:0]       xfer_count,
    output logic              err
);

    localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);

    if (MIN_HOLD < 1 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("cdc_req_sender: MIN_HOLD must be >= 1 and TIMEOUT_CYC >= 2");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        REQ          = 2'd1,
        WAIT_ACK_LOW = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                en_q, en_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [15:0]         cnt_q, cnt_d;

    assign in_ready    = (state_q == IDLE) && !ack_sync;
    assign busy        = (state_q != IDLE);
    assign sync_data   = data_q;
    assign sync_enable = en_q;
    assign xfer_count  = cnt_q;

`ifdef CDC_REQ_SENDER_TIMEOUT_EN
    localparam int PH_W = $clog2(TIMEOUT_CYC);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(TIMEOUT_CYC - 1);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            err_q, err_d;
    state_t          state_n;
    logic            en_n;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        en_d    = en_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                en_d = 1'b0;
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    en_d    = 1'b1;
                    hold_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                en_d = 1'b1;
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                // Only the ack level on the hold-expiry cycle counts; earlier ack pulses are ignored.
                if (ack_sync && (hold_q == HOLD_LAST)) begin
                    en_d    = 1'b0;
                    state_d = WAIT_ACK_LOW;
                end
            end
            WAIT_ACK_LOW: begin
                en_d = 1'b0;
                if (!ack_sync) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

`ifdef CDC_REQ_SENDER_TIMEOUT_EN
    // Abort a phase that has stalled; the word is dropped and xfer_count is left alone.
    always_comb begin
        state_n = state_d;
        en_n    = en_d;
        err_d   = err_q;
        phase_d = phase_q;
        if ((state_q != IDLE) && (state_d == state_q) && (phase_q == PH_LAST)) begin
            state_n = IDLE;
            en_n    = 1'b0;
            err_d   = 1'b1;
        end
        if (state_n != state_q) begin
            phase_d = '0;
        end else if (state_q != IDLE) begin
            phase_d = phase_q + PH_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            en_q    <= 1'b0;
            hold_q  <= '0;
            cnt_q   <= '0;
`ifdef CDC_REQ_SENDER_TIMEOUT_EN
            phase_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
`ifdef CDC_REQ_SENDER_TIMEOUT_EN
            state_q <= state_n;
            en_q    <= en_n;
            phase_q <= phase_d;
            err_q   <= err_d;
`else
            state_q <= state_d;
            en_q    <= en_d;
`endif
        end
    end

endmodule

// File: tb/tb_cdc_req_sender.sv
// Directed bench for cdc_req_sender: stimulus pushes expected words and enable-high lengths; a negedge monitor checks them.
module tb_cdc_req_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  sync_data;
    logic        sync_enable;
    logic        ack_sync;
    logic        busy;
    logic [15:0] xfer_count;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    int exp_word[$];
    int exp_len[$];
    int cur_word = 0;
    int run_len = 0;
    logic prev_en = 1'b0;

    cdc_req_sender #(.DATA_W(8), .MIN_HOLD(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sync_data(sync_data), .sync_enable(sync_enable),
        .ack_sync(ack_sync), .busy(busy), .xfer_count(xfer_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string nm, input int en, input int rdy, input int bsy, input int cnt);
        @(negedge clk);
        check({nm, "_en"}, int'(sync_enable), en);
        check({nm, "_rdy"}, int'(in_ready), rdy);
        check({nm, "_busy"}, int'(busy), bsy);
        check({nm, "_cnt"}, int'(xfer_count), cnt);
        #1;
    endtask

    // Scoreboard monitor: pops the expected word on every enable rise and the expected high length on every fall.
    always @(negedge clk) begin
        if (sync_enable && !prev_en) begin
            if (exp_word.size() == 0) begin
                check("unexpected_accept", 1, 0);
            end else begin
                cur_word = exp_word.pop_front();
                check("accept_word", int'(sync_data), cur_word);
            end
            run_len = 1;
        end else if (sync_enable) begin
            check("data_stable", int'(sync_data), cur_word);
            run_len++;
        end
        if (!sync_enable && prev_en) begin
            if (exp_len.size() == 0) check("unexpected_release", 1, 0);
            else check("enable_len", run_len, exp_len.pop_front());
        end
        prev_en = sync_enable;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; ack_sync = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_data", int'(sync_data), 0);
        check("rst_err", int'(err), 0);
        #1;
        look("rst", 0, 1, 0, 0);

        // Single transfer 0xA5, ack rises early, falls 3 cycles after enable drops.
        in_valid = 1'b1; in_data = 8'hA5;
        exp_word.push_back(8'hA5); exp_len.push_back(4);
        tick();                                 // edge N: accept
        in_valid = 1'b0;
        look("x1_n", 1, 0, 1, 0);
        tick();                                 // N+1
        tick();                                 // N+2
        ack_sync = 1'b1;
        tick();                                 // N+3
        look("x1_n3", 1, 0, 1, 0);
        tick();                                 // N+4: release
        look("x1_n4", 0, 0, 1, 0);
        repeat (3) tick();                      // N+7
        ack_sync = 1'b0;
        look("x1_n7", 0, 0, 1, 0);
        tick();                                 // N+8: back to IDLE
        look("x1_n8", 0, 1, 0, 1);

        // Hold/stability: in_valid stays high, in_data toggles; next word 0x96 taken only after IDLE.
        in_valid = 1'b1; in_data = 8'h3C;
        exp_word.push_back(8'h3C); exp_len.push_back(4);
        tick();                                 // M: accept 0x3C
        in_data = 8'h96; ack_sync = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();                             // M+k
            in_data = (k % 2 == 1) ? 8'h5A : 8'h96;
            if (k == 5) ack_sync = 1'b0;
        end
        exp_word.push_back(8'h96); exp_len.push_back(4);
        @(negedge clk);
        check("hold_last_word", int'(sync_data), 8'h3C);
        check("hold_idle_rdy", int'(in_ready), 1);
        check("hold_cnt", int'(xfer_count), 2);
        #1;
        tick();                                 // M+7: accept 0x96
        in_valid = 1'b0; ack_sync = 1'b1;
        look("hold_2nd", 1, 0, 1, 2);
        repeat (4) tick();                      // M+11: release
        ack_sync = 1'b0;
        tick();                                 // M+12
        tick();                                 // M+13
        look("hold_done", 0, 1, 0, 3);

        // Ack glitch before hold expiry is ignored; late ack stretches enable to 6 cycles.
        in_valid = 1'b1; in_data = 8'h0F;
        exp_word.push_back(8'h0F); exp_len.push_back(6);
        tick();                                 // P
        in_valid = 1'b0; ack_sync = 1'b1;
        tick();                                 // P+1
        ack_sync = 1'b0;
        repeat (4) tick();                      // P+5
        look("glitch_p5", 1, 0, 1, 3);
        ack_sync = 1'b1;
        tick();                                 // P+6: release
        ack_sync = 1'b0;
        tick();                                 // P+7
        look("glitch_done", 0, 1, 0, 4);

        // Stale ack in IDLE blocks acceptance.
        ack_sync = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        repeat (3) tick();
        look("stale", 0, 0, 0, 4);
        check("stale_data", int'(sync_data), 8'h0F);
        in_valid = 1'b0; ack_sync = 1'b0;
        tick();

`ifdef CDC_REQ_SENDER_TIMEOUT_EN
        in_valid = 1'b1; in_data = 8'h77;
        exp_word.push_back(8'h77); exp_len.push_back(16);
        tick();                                 // T
        in_valid = 1'b0;
        repeat (15) tick();                     // T+15
        look("to_pre", 1, 0, 1, 4);
        check("to_pre_err", int'(err), 0);
        tick();                                 // T+16: abort
        look("to_abort", 0, 1, 0, 4);
        check("to_err", int'(err), 1);
        in_valid = 1'b1; in_data = 8'h11;
        exp_word.push_back(8'h11); exp_len.push_back(4);
        tick();
        in_valid = 1'b0; ack_sync = 1'b1;
        repeat (4) tick();
        ack_sync = 1'b0;
        repeat (2) tick();
        look("to_next", 0, 1, 0, 5);
        check("to_err_sticky", int'(err), 1);
`endif

        // Reset during REQ aborts the handshake.
        in_valid = 1'b1; in_data = 8'h42;
        exp_word.push_back(8'h42); exp_len.push_back(2);
        tick();                                 // R
        in_valid = 1'b0;
        tick();                                 // R+1
        rst = 1'b0;
        tick();                                 // R+2: reset
        rst = 1'b1;
        look("midrst", 0, 1, 0, 0);
        check("midrst_data", int'(sync_data), 0);
        check("midrst_err", int'(err), 0);
        repeat (2) tick();

        check("sb_words_left", exp_word.size(), 0);
        check("sb_lens_left", exp_len.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
